// File: rtl/axon_pkg.sv
// Shared types for the AXON drain/feed blocks: FSM encoding and default psum width.
package axon_pkg;

  localparam int AXON_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SPACE = 2'd1,
    ST_EJECT      = 2'd2,
    ST_DRAIN      = 2'd3
  } axon_state_e;

endpackage

// File: rtl/axon_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head visible the cycle after the first push.
// Push and pop may coincide at any fill level; a pop on empty is ignored.
module axon_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A simultaneous pop frees the slot, so a push on full is accepted alongside it.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axon_output_collector.sv
// Ejects one PE output chain and streams its NUM_PE psums (tail PE first, last on PE0); eject 1 cycle after start,
// first word valid 3 cycles after start. Frames wait for FIFO room since the chain cannot stall; m_ready only pops.
module axon_output_collector
  import axon_pkg::*;
#(
  parameter int DATA_WIDTH = AXON_DATA_WIDTH,
  parameter int NUM_PE     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] chain_in,
  output logic                  output_eject_ctrl,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int NW = $clog2(NUM_PE);

  axon_state_e     state_q;
  logic [NW-1:0]   cnt_q;
  logic            eject_q;
  logic            done_q;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [DATA_WIDTH:0] fifo_head;
  logic            last_word;
  logic [CW:0]     free_w;
  logic            space_ok;
  logic            unused_fifo_full;

  assign last_word = (cnt_q == NW'(NUM_PE - 1));
  assign fifo_push = (state_q == ST_DRAIN);
  assign fifo_pop  = m_valid && m_ready;

  // Room is judged after this cycle's pop so a draining stream frees space immediately.
  assign free_w   = (CW+1)'(FIFO_DEPTH) - {1'b0, fifo_count} + {{CW{1'b0}}, fifo_pop};
  assign space_ok = (free_w >= (CW+1)'(NUM_PE));

  assign unused_fifo_full = fifo_full;

  axon_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (fifo_push),
    .push_dat_i ({last_word, chain_in}),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      eject_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      eject_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (space_ok) begin
              state_q <= ST_EJECT;
              eject_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT_SPACE;
            end
          end
        end
        ST_WAIT_SPACE: begin
          if (space_ok) begin
            state_q <= ST_EJECT;
            eject_q <= 1'b1;
          end
        end
        ST_EJECT: begin
          state_q <= ST_DRAIN;
          cnt_q   <= '0;
        end
        ST_DRAIN: begin
          cnt_q <= cnt_q + NW'(1);
          if (last_word) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign output_eject_ctrl = eject_q;
  assign done              = done_q;
  assign busy              = (state_q != ST_IDLE);
  assign m_valid           = !fifo_empty;
  assign m_data            = fifo_empty ? '0   : fifo_head[DATA_WIDTH-1:0];
  assign m_last            = fifo_empty ? 1'b0 : fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_axon_output_collector.sv
// Bench for axon_output_collector: cycle table for one frame plus directed multi-cycle sequences.
module tb_axon_output_collector;

  localparam int NUM_PE = 8;
  localparam int DW     = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] chain_in;
  logic          output_eject_ctrl;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          done;

  logic          ready_cmd;
  logic          rand_ready;
  logic [DW-1:0] base;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } word_t;
  word_t exp_q[$];

  typedef struct {
    logic          start;
    logic          eject;
    logic          busy;
    logic          done;
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
  } vec_t;
  vec_t tv[12];

  axon_output_collector #(
    .DATA_WIDTH (DW),
    .NUM_PE     (NUM_PE),
    .FIFO_DEPTH (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .chain_in          (chain_in),
    .output_eject_ctrl (output_eject_ctrl),
    .m_data            (m_data),
    .m_last            (m_last),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .busy              (busy),
    .done              (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PE chain model: eject loads PE[i] = base+i, otherwise words shift toward the tail.
  logic [DW-1:0] chain_q [NUM_PE];
  always @(posedge clk) begin
    for (int i = 0; i < NUM_PE; i++) begin
      if (output_eject_ctrl)  chain_q[i] <= base + DW'(i);
      else if (i == 0)        chain_q[i] <= '0;
      else                    chain_q[i] <= chain_q[i-1];
    end
  end
  assign chain_in = chain_q[NUM_PE-1];

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_frame(input logic [DW-1:0] b);
    for (int k = 0; k < NUM_PE; k++) begin
      exp_q.push_back({b + DW'(NUM_PE - 1 - k), (k == NUM_PE - 1)});
    end
  endtask

  task automatic mon();
    word_t e;
    if (dut.u_fifo.push_i && dut.u_fifo.full_o && !dut.u_fifo.pop_i) begin
      checks++;
      $display("FAIL push_while_full: push with fifo full, count=%0d", dut.u_fifo.count_o);
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL sb_extra: unexpected word 0x%0h last=%0b", m_data, m_last);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", 32'(m_data), 32'(e.d));
        check("sb_last", 32'(m_last), 32'(e.l));
      end
    end
  endtask

  task automatic neg();
    @(negedge clk);
    mon();
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    neg();
    pos();
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      neg();
      seen = done;
      pos();
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_eject"}, 32'(output_eject_ctrl), 32'd0);
    check({tag, "_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_last"},  32'(m_last), 32'd0);
    check({tag, "_data"},  32'(m_data), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ready_cmd = 1'b0; rand_ready = 1'b0; base = '0;

    // Single-frame cycle table, cycle 0 = start accepted, psums 0x10..0x17.
    for (int r = 0; r < 12; r++) begin
      tv[r].start = (r == 0);
      tv[r].eject = (r == 1);
      tv[r].busy  = (r >= 1 && r <= 9);
      tv[r].done  = (r == 10);
      tv[r].valid = (r >= 3 && r <= 10);
      tv[r].data  = (r >= 3 && r <= 10) ? DW'(16'h0017 - 16'(r - 3)) : '0;
      tv[r].last  = (r == 10);
    end

    repeat (2) cyc();
    neg(); check_all_zero("reset"); pos();
    rst_n = 1'b1;
    ready_cmd = 1'b1;
    repeat (2) cyc();

    // Single frame
    base = 16'h0010;
    push_frame(16'h0010);
    for (int r = 0; r < 12; r++) begin
      start = tv[r].start;
      neg();
      check($sformatf("t1_c%0d_eject", r), 32'(output_eject_ctrl), 32'(tv[r].eject));
      check($sformatf("t1_c%0d_busy", r),  32'(busy),  32'(tv[r].busy));
      check($sformatf("t1_c%0d_done", r),  32'(done),  32'(tv[r].done));
      check($sformatf("t1_c%0d_valid", r), 32'(m_valid), 32'(tv[r].valid));
      if (tv[r].valid) begin
        check($sformatf("t1_c%0d_data", r), 32'(m_data), 32'(tv[r].data));
        check($sformatf("t1_c%0d_last", r), 32'(m_last), 32'(tv[r].last));
      end
      pos();
    end
    start = 1'b0;
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: two frames fill the FIFO, third waits for space
    ready_cmd = 1'b0;
    cyc();
    base = 16'h0100; push_frame(16'h0100);
    start = 1'b1; cyc(); start = 1'b0;
    wait_done("bp_done1", 30);
    base = 16'h0200; push_frame(16'h0200);
    start = 1'b1; cyc(); start = 1'b0;
    neg(); check("bp_eject2", 32'(output_eject_ctrl), 32'd1); pos();
    wait_done("bp_done2", 30);
    neg(); check("bp_full_valid", 32'(m_valid), 32'd1); pos();
    base = 16'h0300; push_frame(16'h0300);
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      neg();
      check("bp_wait_eject", 32'(output_eject_ctrl), 32'd0);
      check("bp_wait_busy", 32'(busy), 32'd1);
      pos();
    end
    ready_cmd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      neg(); check($sformatf("bp_pop%0d_eject", i), 32'(output_eject_ctrl), 32'd0); pos();
    end
    neg(); check("bp_eject3", 32'(output_eject_ctrl), 32'd1); pos();
    wait_done("bp_done3", 30);
    repeat (20) cyc();
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Start during DRAIN is ignored
    base = 16'h0400; push_frame(16'h0400);
    for (int c = 0; c < 26; c++) begin
      start = (c == 0 || c == 5);
      neg();
      if (c == 1)  check("ign_eject_c1", 32'(output_eject_ctrl), 32'd1);
      if (c >= 2)  check($sformatf("ign_eject_c%0d", c), 32'(output_eject_ctrl), 32'd0);
      if (c == 10) check("ign_done_c10", 32'(done), 32'd1);
      pos();
    end
    start = 1'b0;
    check("ign_queue_empty", 32'(exp_q.size()), 32'd0);

    // Start in the done cycle gives a back-to-back frame
    base = 16'h0500; push_frame(16'h0500);
    for (int c = 0; c < 13; c++) begin
      start = (c == 0 || c == 10);
      if (c == 10) begin
        base = 16'h0600;
        push_frame(16'h0600);
      end
      neg();
      if (c == 10) check("b2b_done_c10", 32'(done), 32'd1);
      if (c == 11) check("b2b_eject_c11", 32'(output_eject_ctrl), 32'd1);
      pos();
    end
    start = 1'b0;
    wait_done("b2b_done2", 20);
    repeat (5) cyc();
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    // FIFO wrap: five frames under random m_ready
    rand_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      base = 16'hA000 + 16'(f) * 16'h0111;
      push_frame(base);
      start = 1'b1;
      neg(); check($sformatf("wrap_f%0d_idle", f), 32'(busy), 32'd0); pos();
      start = 1'b0;
      wait_done($sformatf("wrap_f%0d_done", f), 100);
    end
    rand_ready = 1'b0;
    ready_cmd = 1'b1;
    repeat (30) cyc();
    check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
    neg(); check("wrap_valid_idle", 32'(m_valid), 32'd0); pos();

    // Reset in the middle of DRAIN after three captures
    ready_cmd = 1'b0;
    cyc();
    base = 16'h0700;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (4) cyc();
    rst_n = 1'b0;
    neg(); check_all_zero("rst_mid"); pos();
    neg(); check_all_zero("rst_hold"); pos();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      neg();
      check($sformatf("rst_post%0d_valid", i), 32'(m_valid), 32'd0);
      check($sformatf("rst_post%0d_busy", i), 32'(busy), 32'd0);
      pos();
    end
    ready_cmd = 1'b1;
    base = 16'h0800; push_frame(16'h0800);
    start = 1'b1; cyc(); start = 1'b0;
    wait_done("rst_frame_done", 30);
    repeat (5) cyc();
    check("rst_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axon_output_collector.md
# axon_output_collector

Drain-side controller for one AXON PE output chain. On `start`, it pulses the chain's eject control for one cycle, then captures the `NUM_PE` partial sums as they shift out of the chain tail. The words are buffered in a local FIFO and presented on a valid/ready stream with a last-of-frame marker. It sits between the tail of an `axon_pe_h` row/column and the ofmap writeback path.

## Interface
- `DATA_WIDTH`, 16, width of one psum word; must match the PE chain.
- `NUM_PE`, 8, number of PEs in the chain; also the number of words per frame (≥2).
- `FIFO_DEPTH`, 16, buffer entries; power of two, ≥ `NUM_PE`.
- `clk` in 1, single clock.
- `rst_n` in 1, reset; asynchronous, active-low.
- `start` in 1, request one eject/drain frame; sampled only in IDLE.
- `chain_in` in `DATA_WIDTH`, `output_out` of the chain's tail PE.
- `output_eject_ctrl` out 1, broadcast to every PE's `output_eject_ctrl`; registered.
- `m_data` out `DATA_WIDTH`, stream data (FIFO head).
- `m_last` out 1, high on the final word of a frame (PE index 0).
- `m_valid` out 1, FIFO non-empty.
- `m_ready` in 1, downstream accept; transfer when `m_valid && m_ready`.
- `busy` out 1, state ≠ IDLE.
- `done` out 1, one-cycle pulse after the last capture of a frame.

## Operation
- **FSM states:** IDLE, WAIT_SPACE, EJECT, DRAIN.
- **IDLE + `start`:**
  - If `free ≥ NUM_PE`, go to EJECT; otherwise go to WAIT_SPACE.
  - `free = FIFO_DEPTH − count`, evaluated with that cycle's pop included.
- **WAIT_SPACE:** go to EJECT when `free ≥ NUM_PE`. The chain cannot stall, so a frame is never started without room for all of it.
- **EJECT:** lasts exactly one cycle with `output_eject_ctrl=1`, then goes to DRAIN with `cnt=0`.
- **DRAIN:**
  - Every cycle, push `{last, chain_in}` at the closing edge.
  - `last = (cnt==NUM_PE−1)`; `cnt` increments.
  - After the `NUM_PE`-th push, go to IDLE and assert `done` in the following cycle.
- **Word order:** tail PE (index `NUM_PE−1`) first, PE 0 last.
- **Ignored `start`:** `start` while `busy` is ignored and not queued. `start` in the `done` cycle is accepted, since the FSM is already in IDLE.
- **FIFO:**
  - Synchronous, first-word-fall-through, `DATA_WIDTH+1` bits wide.
  - Push and pop in the same cycle are legal at any count.
  - Push while full cannot occur by construction. The bench asserts this.
  - Read/write pointers wrap modulo `FIFO_DEPTH`; `count` is `clog2(FIFO_DEPTH)+1` bits.
- **Data path:** no arithmetic on data; words pass bit-exact.
- **Reset (also mid-frame):**
  - FSM returns to IDLE; `cnt`, pointers and `count` are cleared.
  - All outputs go to 0: `output_eject_ctrl`, `m_valid`, `m_last`, `m_data`, `busy`, `done`.
  - The in-flight frame is discarded.

## Timing
- Take the cycle where `start` is accepted in IDLE (with space available) as cycle 0.
  - `output_eject_ctrl=1` in cycle 1 only.
  - PEs load psums at the end of cycle 1.
  - `chain_in` carries PE[`NUM_PE−1`] in cycle 2 and PE[`NUM_PE−1−k`] in cycle 2+k.
- Captures happen at the ends of cycles 2 … `NUM_PE+1`.
- `done=1` in cycle `NUM_PE+2`; `busy=1` in cycles 1 … `NUM_PE+1`.
- `m_valid` first rises in cycle 3, when the FIFO was empty at start.
- Start-to-start throughput is one frame per `NUM_PE+2` cycles when downstream keeps up.
- `m_valid` and `m_data` must not depend combinationally on `m_ready`.

## Structure
- Shared package `axon_pkg` holds:
  - FSM state encoding localparams (`ST_IDLE`, `ST_WAIT_SPACE`, `ST_EJECT`, `ST_DRAIN`).
  - The default `DATA_WIDTH`.
- One sub-module, `axon_sync_fifo` (parameters `WIDTH`, `DEPTH`), with ports push/pop/full/empty/count. It is reusable by the ifmap/weight feeders.

## Test plan
- **Single frame:** `NUM_PE=8`, chain model with psums 0x0010..0x0017 for PE0..PE7, `start`, `m_ready=1`.
  - `output_eject_ctrl` high exactly cycle 1.
  - Stream is 0x0017, 0x0016 … 0x0010.
  - `m_last` only on 0x0010; `done` in cycle 10.
- **Backpressure:** `m_ready=0`, two `start`s.
  - First frame fills 8 entries.
  - Second frame proceeds (free = 8).
  - A third `start` sits in WAIT_SPACE with `output_eject_ctrl` low.
  - It begins EJECT the cycle after 8 pops complete (`m_ready` raised).
- **Busy start:** `start` pulsed during DRAIN is ignored, giving exactly one frame. `start` in the `done` cycle gives a back-to-back frame with eject in the following cycle.
- **FIFO wrap:** 5 consecutive frames with random `m_ready` (50%).
  - All 40 words arrive in order with correct `m_last` positions.
  - No push-while-full assertion fires.
- **Reset mid-DRAIN:** assert `rst_n=0` after 3 captures.
  - All outputs are 0 during reset; `m_valid` stays 0 after release.
  - The next `start` yields a clean full frame.
